spi_flash_cmd: RTL and testbench
================================

// Module: spi_flash_cmd
// PURPOSE
//  Generic SPI mode-0 command engine for the on-board serial flash. One start pulse issues an opcode,
//  0-3 address bytes, then reads 0..MAX_RD_BYTES response bytes into a parallel register.
//  Replaces fixed single-opcode ID probes: JEDEC ID, status read, WREN and data reads share one engine.
//  Sits between board-level control logic (buttons/LED debug, later a loader FSM) and the flash pins.
// PARAMETERS
//  CLK_DIV       6  clk12MHz cycles per SCK half-period (>=1); 6 -> 1 MHz SCK
//  MAX_RD_BYTES  4  max response bytes; rd_data width = 8*MAX_RD_BYTES
// PORTS
//  clk12MHz  in   1                 system clock
//  rst       in   1                 reset, synchronous, active-low
//  start     in   1                 1-cycle request; accepted only while busy=0
//  opcode    in   8                 command byte, sent first, MSB first
//  addr      in   24                address, sent MSB byte first; only low addr_len bytes used
//  addr_len  in   2                 address bytes 0..3
//  rd_len    in   $clog2(MAX_RD_BYTES+1)  response bytes to read; >MAX_RD_BYTES clamps to MAX_RD_BYTES
//  busy      out  1                 high from cycle after accepted start until done
//  done      out  1                 1-cycle pulse, transaction complete, rd_data valid
//  rd_data   out  8*MAX_RD_BYTES    response; first byte received is most significant of used bytes
//  cs_n      out  1                 flash chip select, active-low
//  sck       out  1                 SPI clock, idles low (mode 0)
//  sdo       out  1                 MOSI
//  sdi       in   1                 MISO
// BEHAVIOUR
//  Reset (rst=0 at clk edge): cs_n=1, sck=0, sdo=0, busy=0, done=0, rd_data=0, state IDLE, counters 0.
//  Reset mid-transaction aborts: next cycle outputs at reset values; no done pulse; flash sees CS rise.
//  start+inputs latched on acceptance; later input changes do not affect current transaction.
//  start while busy=1 or during done cycle is ignored (no queueing).
//  Half-period tick: counter 0..CLK_DIV-1 runs only while busy; tick when counter==CLK_DIV-1.
//  States: IDLE -> CS_SETUP -> TX -> (RX if rd_len>0) -> CS_HOLD -> CS_IDLE -> IDLE.
//   IDLE: cs_n=1, sck=0. On start: cs_n=0, sdo=opcode[7], busy=1, go CS_SETUP.
//   CS_SETUP: wait 1 half-period, then TX.
//   TX: N_tx=8*(1+addr_len) bits. Per bit: low half (sdo stable), tick -> sck=1, high half, tick -> sck=0
//       and sdo=next bit. After last bit's falling edge: RX if rd_len>0 else CS_HOLD.
//   RX: 8*rd_len bits; sdi sampled on the clk cycle sck goes 1, shifted into rd_data from bit 0 (left shift).
//       sdo held 0 in RX. After last falling edge -> CS_HOLD.
//   CS_HOLD: sck=0, cs_n=0 for 1 half-period, then cs_n=1 -> CS_IDLE.
//   CS_IDLE: cs_n=1 for 1 half-period (min deselect time), then done=1, busy=0, IDLE.
//  Latency: N=1+addr_len+rd_len bytes; busy high exactly CLK_DIV*(3+16*N) cycles; done on the cycle busy falls.
//  rd_data: cleared to 0 at acceptance; unused upper bytes stay 0; holds value until next accepted start.
//  sck never glitches: changes only on tick; exactly 8*N rising edges per transaction.
//  rd_len=0 and addr_len=0 (e.g. WREN) legal: 8 SCK pulses only.
// STRUCTURE
//  Package spi_flash_pkg: opcode constants (OP_WREN 8'h06, OP_RDSR 8'h05, OP_READ 8'h03, OP_JEDEC_ID 8'h9F),
//   state encoding localparams, byte-count width function.
//  Sub-module spi_sck_tick: CLK_DIV half-period counter with enable, emits tick; rest is one FSM + shift regs.
// TESTING (bench: behavioural flash model, mode 0, drives sdi on sck falling edge)
//  1 OP_JEDEC_ID, addr_len=0, rd_len=3, model returns EF 40 16 -> rd_data[23:0]=24'hEF4016, upper 0, 32 sck rises.
//  2 OP_READ, addr=24'h012345, addr_len=3, rd_len=4, data A5 5A FF 00 -> model sees 03 01 23 45, rd_data=32'hA55AFF00.
//  3 OP_WREN, rd_len=0, CLK_DIV=6 -> 8 sck pulses, busy exactly 6*19=114 cycles, done 1 cycle, rd_data=0.
//  4 start pulsed again mid-transaction with OP_RDSR -> ignored; model sees only first command; single done.
//  5 rst=0 during RX byte 2 -> next cycle cs_n=1, sck=0, busy=0, no done; fresh start then completes normally.
//  6 rd_len=7 with MAX_RD_BYTES=4 -> clamps: 32 RX bits, cs_n high after 4 bytes; check CS setup/hold >= CLK_DIV.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants for the serial-flash command engine: flash opcodes,
// FSM state encoding and a byte-count width helper.
package spi_flash_pkg;

    localparam logic [7:0] OP_WREN     = 8'h06;
    localparam logic [7:0] OP_RDSR     = 8'h05;
    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_JEDEC_ID = 8'h9F;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_TX       = 3'd2;
    localparam logic [2:0] ST_RX       = 3'd3;
    localparam logic [2:0] ST_CS_HOLD  = 3'd4;
    localparam logic [2:0] ST_CS_IDLE  = 3'd5;

    // Bits needed to hold a count in the range 0..n.
    function automatic int byte_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_sck_tick.sv
// Half-period timer for the SPI clock: counts 0..CLK_DIV-1 while enabled
// and flags the last cycle of each half-period.
module spi_sck_tick #(
    parameter int CLK_DIV = 6
) (
    input  logic clk12MHz,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_flash_cmd.sv
// SPI mode-0 command engine: opcode, 0-3 address bytes, then up to
// MAX_RD_BYTES response bytes collected into rd_data.
module spi_flash_cmd
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV      = 6,
    parameter int MAX_RD_BYTES = 4
) (
    input  logic                                clk12MHz,
    input  logic                                rst,
    input  logic                                start,
    input  logic [7:0]                          opcode,
    input  logic [23:0]                         addr,
    input  logic [1:0]                          addr_len,
    input  logic [byte_cnt_w(MAX_RD_BYTES)-1:0] rd_len,
    output logic                                busy,
    output logic                                done,
    output logic [8*MAX_RD_BYTES-1:0]           rd_data,
    output logic                                cs_n,
    output logic                                sck,
    output logic                                sdo,
    input  logic                                sdi
);
    localparam int RL_W  = byte_cnt_w(MAX_RD_BYTES);
    localparam int RD_W  = 8 * MAX_RD_BYTES;
    localparam int BIT_W = byte_cnt_w(32 + RD_W);

    logic [2:0]       state_q, state_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      tx_q, tx_d;
    logic [RL_W-1:0]  rx_len_q, rx_len_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [RD_W-1:0]  rd_data_q, rd_data_d;

    logic            tick;
    logic            accept;
    logic            last_bit;
    logic [RL_W-1:0] rd_len_clamped;

    spi_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .en       (busy_q),
        .tick     (tick)
    );

    // The done cycle is spent in IDLE, so it must explicitly refuse a start.
    assign accept         = (state_q == ST_IDLE) && start && !done_q;
    assign last_bit       = (bit_cnt_q == BIT_W'(1));
    assign rd_len_clamped = (rd_len > RL_W'(MAX_RD_BYTES)) ? RL_W'(MAX_RD_BYTES) : rd_len;

    always_ff @(posedge clk12MHz) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_q      <= '0;
            rx_len_q  <= '0;
            bit_cnt_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tx_q      <= tx_d;
            rx_len_q  <= rx_len_d;
            bit_cnt_q <= bit_cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = ST_CS_SETUP;
            ST_CS_SETUP: if (tick) state_d = ST_TX;
            ST_TX:       if (tick && sck_q && last_bit)
                             state_d = (rx_len_q != '0) ? ST_RX : ST_CS_HOLD;
            ST_RX:       if (tick && sck_q && last_bit) state_d = ST_CS_HOLD;
            ST_CS_HOLD:  if (tick) state_d = ST_CS_IDLE;
            ST_CS_IDLE:  if (tick) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sck_d     = sck_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tx_d      = tx_q;
        rx_len_d  = rx_len_q;
        bit_cnt_d = bit_cnt_q;
        rd_data_d = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    // Left-align opcode and used address bytes; zeros shift in behind
                    // them, which leaves sdo low for the read phase.
                    tx_d      = {opcode, addr << (5'd24 - {addr_len, 3'b000})};
                    rx_len_d  = rd_len_clamped;
                    bit_cnt_d = BIT_W'({addr_len, 3'b000}) + BIT_W'(8);
                    rd_data_d = '0;
                end
            end
            ST_TX: begin
                if (tick) begin
                    sck_d = !sck_q;
                    if (sck_q) begin
                        tx_d = {tx_q[30:0], 1'b0};
                        if (last_bit) begin
                            bit_cnt_d = BIT_W'({rx_len_q, 3'b000});
                        end else begin
                            bit_cnt_d = bit_cnt_q - BIT_W'(1);
                        end
                    end
                end
            end
            ST_RX: begin
                if (tick) begin
                    sck_d = !sck_q;
                    if (!sck_q) begin
                        rd_data_d = {rd_data_q[RD_W-2:0], sdi};
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end
            end
            ST_CS_HOLD: begin
                if (tick) cs_n_d = 1'b1;
            end
            ST_CS_IDLE: begin
                if (tick) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign cs_n    = cs_n_q;
    assign sck     = sck_q;
    assign sdo     = tx_q[31];

endmodule

// File: tb/tb_spi_flash_cmd.sv
// Directed plus randomized bench for spi_flash_cmd against a behavioural
// mode-0 flash model that records MOSI and replays a response byte stream.
module tb_spi_flash_cmd;
    import spi_flash_pkg::*;

    localparam int CLK_DIV = 6;
    localparam int MAXB    = 4;
    localparam int LIMIT   = 5000;

    logic        clk12MHz = 1'b0;
    logic        rst      = 1'b0;
    logic        start    = 1'b0;
    logic [7:0]  opcode   = '0;
    logic [23:0] addr     = '0;
    logic [1:0]  addr_len = '0;
    logic [2:0]  rd_len   = '0;
    logic        busy, done, cs_n, sck, sdo;
    logic [31:0] rd_data;
    logic        sdi = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Flash model state
    int          m_rise    = 0;
    int          m_tx_bits = 8;
    logic [63:0] m_resp    = '0;
    logic        mosi_q[$];

    spi_flash_cmd #(.CLK_DIV(CLK_DIV), .MAX_RD_BYTES(MAXB)) dut (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .addr     (addr),
        .addr_len (addr_len),
        .rd_len   (rd_len),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .cs_n     (cs_n),
        .sck      (sck),
        .sdo      (sdo),
        .sdi      (sdi)
    );

    always #5 clk12MHz = ~clk12MHz;

    always @(posedge sck) begin
        if (cs_n === 1'b0) begin
            mosi_q.push_back(sdo);
            m_rise = m_rise + 1;
        end
    end

    // Mode 0 slave: shift the next response bit out on the falling edge.
    always @(negedge sck) begin
        if (cs_n === 1'b0 && m_rise >= m_tx_bits && (m_rise - m_tx_bits) < 64)
            sdi = m_resp[63 - (m_rise - m_tx_bits)];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_arm(input logic [1:0] al, input logic [63:0] resp);
        m_rise    = 0;
        m_tx_bits = 8 * (1 + int'(al));
        m_resp    = resp;
        mosi_q.delete();
        sdi       = 1'b0;
    endtask

    task automatic run_txn(input string name, input logic [7:0] op, input logic [23:0] ad,
                           input logic [1:0] al, input logic [2:0] rl,
                           input logic [63:0] resp, input int mid_start);
        int nb, n, busy_cyc, done_cnt, cyc, after, first_rise, last_fall, cs_rise, ntx;
        logic [31:0] exp_rd;
        logic [7:0]  got_b, exp_b;
        logic        prev_sck, rx_sdo_or;

        nb = (int'(rl) > MAXB) ? MAXB : int'(rl);
        n  = 1 + int'(al) + nb;
        exp_rd = '0;
        for (int i = 0; i < nb; i++) exp_rd = (exp_rd << 8) | 32'(resp[63-8*i -: 8]);
        ntx = 1 + int'(al);

        model_arm(al, resp);
        @(negedge clk12MHz);
        opcode = op; addr = ad; addr_len = al; rd_len = rl; start = 1'b1;
        @(negedge clk12MHz);
        start = 1'b0;
        opcode = 8'($urandom); addr = 24'($urandom);
        addr_len = 2'($urandom); rd_len = 3'($urandom);

        busy_cyc = 0; done_cnt = 0; cyc = 0; after = -1;
        first_rise = -1; last_fall = -1; cs_rise = -1; prev_sck = 1'b0;
        while (cyc < LIMIT && after != 0) begin
            if (busy === 1'b1) busy_cyc++;
            if (sck === 1'b1 && first_rise < 0) first_rise = cyc;
            if (sck === 1'b0 && prev_sck === 1'b1) last_fall = cyc;
            if (cs_n === 1'b1 && cs_rise < 0) cs_rise = cyc;
            prev_sck = sck;
            start = 1'b0;
            if (mid_start > 0 && cyc == mid_start) begin
                start = 1'b1; opcode = OP_RDSR; addr_len = 2'd0; rd_len = 3'd1;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (after < 0) begin
                    after = 4;
                    start = 1'b1;
                end
            end else if (after > 0) begin
                after--;
            end
            @(negedge clk12MHz);
            cyc++;
        end
        start = 1'b0;

        chk({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, ".busy_cycles"}, 64'(busy_cyc), 64'(CLK_DIV * (3 + 16 * n)));
        chk({name, ".sck_rises"}, 64'(m_rise), 64'(8 * n));
        chk({name, ".rd_data"}, 64'(rd_data), 64'(exp_rd));
        chk({name, ".cs_setup_ok"}, 64'(first_rise >= CLK_DIV), 64'd1);
        chk({name, ".cs_hold_ok"}, 64'((cs_rise - last_fall) >= CLK_DIV && last_fall > 0), 64'd1);
        chk({name, ".idle_pins"}, {61'd0, cs_n, sck, busy}, 64'd4);
        if (mosi_q.size() >= 8 * ntx) begin
            for (int k = 0; k < ntx; k++) begin
                got_b = '0;
                for (int b = 0; b < 8; b++) got_b = {got_b[6:0], mosi_q[8*k+b]};
                exp_b = (k == 0) ? op : ad[8*(int'(al)-k) +: 8];
                chk($sformatf("%s.mosi_byte%0d", name, k), 64'(got_b), 64'(exp_b));
            end
        end
        rx_sdo_or = 1'b0;
        for (int b = 8 * ntx; b < mosi_q.size(); b++) rx_sdo_or = rx_sdo_or | mosi_q[b];
        chk({name, ".sdo_low_in_rx"}, 64'(rx_sdo_or), 64'd0);
        $display("txn %s op=%02h addr=%06h alen=%0d rlen=%0d rd_data=%08h busy=%0d rises=%0d",
                 name, op, ad, al, rl, rd_data, busy_cyc, m_rise);
    endtask

    initial begin
        int cyc, dn;
        logic [1:0] al;
        logic [2:0] rl;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk12MHz);
        chk("reset.cs_n", 64'(cs_n), 64'd1);
        chk("reset.sck", 64'(sck), 64'd0);
        chk("reset.sdo", 64'(sdo), 64'd0);
        chk("reset.busy_done", {62'd0, busy, done}, 64'd0);
        chk("reset.rd_data", 64'(rd_data), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk12MHz);

        run_txn("jedec", OP_JEDEC_ID, 24'h0, 2'd0, 3'd3, 64'hEF4016_0000000000, 0);
        run_txn("read", OP_READ, 24'h012345, 2'd3, 3'd4, 64'hA55AFF00_00000000, 0);
        run_txn("wren", OP_WREN, 24'hABCDEF, 2'd0, 3'd0, 64'hFFFFFFFF_FFFFFFFF, 0);
        run_txn("busy_start", OP_READ, 24'h00BEEF, 2'd2, 3'd2, 64'h1234_000000000000, 50);
        run_txn("clamp", OP_READ, 24'h7F0011, 2'd1, 3'd7, 64'hC3A17E55_99887766, 0);

        // Reset in the middle of the second response byte
        model_arm(2'd0, 64'h11223344_00000000);
        @(negedge clk12MHz);
        opcode = OP_JEDEC_ID; addr_len = 2'd0; rd_len = 3'd3; start = 1'b1;
        @(negedge clk12MHz);
        start = 1'b0;
        cyc = 0;
        while (m_rise < 8 + 8 + 3 && cyc < LIMIT) begin
            @(negedge clk12MHz);
            cyc++;
        end
        chk("abort.reached_rx", 64'(cyc < LIMIT), 64'd1);
        rst = 1'b0;
        @(negedge clk12MHz);
        chk("abort.cs_n", 64'(cs_n), 64'd1);
        chk("abort.sck", 64'(sck), 64'd0);
        chk("abort.busy_done", {62'd0, busy, done}, 64'd0);
        chk("abort.rd_data", 64'(rd_data), 64'd0);
        rst = 1'b1;
        dn = 0;
        repeat (30) begin
            @(negedge clk12MHz);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        chk("abort.quiet", 64'(dn), 64'd0);
        run_txn("after_abort", OP_RDSR, 24'h0, 2'd0, 3'd1, 64'h5A00000000000000, 0);

        // Randomized commands
        for (int t = 0; t < 8; t++) begin
            al = 2'($urandom_range(0, 3));
            rl = 3'($urandom_range(0, 7));
            run_txn($sformatf("rand%0d", t), 8'($urandom), 24'($urandom), al, rl,
                    {$urandom, $urandom}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
